// File: rtl/decoder_pkg.sv
// Shared CSR decode types: operand/address types, CSR op encoding and the
// CONFIG field layout of the machine timer.
package decoder_pkg;

  typedef logic [31:0] word;
  typedef logic [4:0]  r;
  typedef logic [11:0] csr_addr_t;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_t;

  // Timer CONFIG layout; PS occupies [CFG_PS_LSB +: PS_W] with PS_W <= CFG_PS_MAX_W
  localparam int CFG_EN_BIT       = 0;
  localparam int CFG_PERIODIC_BIT = 1;
  localparam int CFG_IE_BIT       = 2;
  localparam int CFG_PS_LSB       = 4;
  localparam int CFG_PS_MAX_W     = 4;
  localparam int CFG_PEND_BIT     = 8;

endpackage

// File: rtl/csr_wdata.sv
// CSR read-modify-write value: new register value from the old value, the op
// and the register or zero-extended immediate operand.
module csr_wdata
  import decoder_pkg::*;
(
  input  word  old,
  input  csr_t op,
  input  word  rs1_data,
  input  r     rs1_zimm,
  output word  wdata
);

  word zimm_ext;

  always_comb begin
    zimm_ext = {27'b0, rs1_zimm};
    wdata    = old;
    unique case (op)
      CSRRW:   wdata = rs1_data;
      CSRRS:   wdata = old | rs1_data;
      CSRRC:   wdata = old & ~rs1_data;
      CSRRWI:  wdata = zimm_ext;
      CSRRSI:  wdata = old | zimm_ext;
      CSRRCI:  wdata = old & ~zimm_ext;
      default: wdata = old;
    endcase
  end

endmodule

// File: rtl/csr_timer.sv
// CSR-mapped machine timer: CONFIG / COMPARE / COUNTER at three adjacent
// addresses, prescaled counter, sticky PEND and a level interrupt.
module csr_timer
  import decoder_pkg::*;
#(
  parameter csr_addr_t BASE_ADDR = 12'h7C0,
  parameter int        PS_W      = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  csr_addr_t addr,
  input  csr_t      op,
  input  word       rs1_data,
  input  r          rs1_zimm,
  output word       out,
  output logic      irq
);

  localparam csr_addr_t CFG_ADDR = BASE_ADDR;
  localparam csr_addr_t CMP_ADDR = BASE_ADDR + csr_addr_t'(1);
  localparam csr_addr_t CNT_ADDR = BASE_ADDR + csr_addr_t'(2);
  // Prescaler must reach 2^PS-1 for the largest PS the field can hold
  localparam int        PRESC_W  = (1 << PS_W) - 1;

  logic                en_q;
  logic                periodic_q;
  logic                ie_q;
  logic [PS_W-1:0]     ps_q;
  logic                pend_q;
  word                 compare_q;
  word                 counter_q;
  logic [PRESC_W-1:0]  presc_q;

  logic [PRESC_W-1:0]  presc_mask;
  logic                tick;
  logic                match;
  logic                wr_cfg;
  logic                wr_cmp;
  logic                wr_cnt;
  word                 cfg_rd;
  word                 wdata;

  always_comb begin
    cfg_rd                           = '0;
    cfg_rd[CFG_EN_BIT]               = en_q;
    cfg_rd[CFG_PERIODIC_BIT]         = periodic_q;
    cfg_rd[CFG_IE_BIT]               = ie_q;
    cfg_rd[CFG_PS_LSB +: PS_W]       = ps_q;
    cfg_rd[CFG_PEND_BIT]             = pend_q;
  end

  always_comb begin
    out = '0;
    if (addr == CFG_ADDR)      out = cfg_rd;
    else if (addr == CMP_ADDR) out = compare_q;
    else if (addr == CNT_ADDR) out = counter_q;
  end

  csr_wdata u_wdata (
    .old      (out),
    .op       (op),
    .rs1_data (rs1_data),
    .rs1_zimm (rs1_zimm),
    .wdata    (wdata)
  );

  assign wr_cfg = en && (addr == CFG_ADDR);
  assign wr_cmp = en && (addr == CMP_ADDR);
  assign wr_cnt = en && (addr == CNT_ADDR);

  assign presc_mask = ~({PRESC_W{1'b1}} << ps_q);
  assign tick       = en_q && (presc_q == presc_mask);
  assign match      = tick && (counter_q == compare_q);
  assign irq        = pend_q & ie_q;

  // Hardware updates first; software writes below override them, except that
  // a hardware PEND set survives a same-cycle software clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
      ps_q       <= '0;
      pend_q     <= 1'b0;
      compare_q  <= '0;
      counter_q  <= '0;
      presc_q    <= '0;
    end else begin
      if (wr_cfg || !en_q || tick) presc_q <= '0;
      else                         presc_q <= presc_q + PRESC_W'(1);

      if (match) begin
        pend_q <= 1'b1;
        if (!periodic_q) en_q <= 1'b0;
      end

      if (tick) begin
        if (!match)          counter_q <= counter_q + 32'd1;
        else if (periodic_q) counter_q <= '0;
      end

      if (wr_cfg) begin
        en_q       <= wdata[CFG_EN_BIT];
        periodic_q <= wdata[CFG_PERIODIC_BIT];
        ie_q       <= wdata[CFG_IE_BIT];
        ps_q       <= wdata[CFG_PS_LSB +: PS_W];
        pend_q     <= wdata[CFG_PEND_BIT] | match;
      end
      if (wr_cmp) compare_q <= wdata;
      if (wr_cnt) counter_q <= wdata;
    end
  end

endmodule

// File: doc/csr_timer.md
# csr_timer

CSR-mapped machine timer, downstream of the decoder's CSR path. It consumes the same CSR access stream as the plain `csr` register (`en`, `addr`, `op`, `rs1_data`, `rs1_zimm`) and serves three adjacent addresses: configuration, compare and counter. A prescaled counter raises a pending flag and an interrupt line toward the interrupt controller on compare match.

## Interface
Parameters:
- `BASE_ADDR`, default `12'h7C0`: address of CONFIG; COMPARE is at `BASE_ADDR+1`, COUNTER at `BASE_ADDR+2`.
- `PS_W`, default 4: width of the prescale-exponent field.

Ports:
- `clk` in, 1: the only clock.
- `reset` in, 1: synchronous, active-high.
- `en` in, 1: CSR access strobe from the decoder.
- `addr` in, `csr_addr_t`: CSR address.
- `op` in, `csr_t`: one of CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI.
- `rs1_data` in, `word`: register operand.
- `rs1_zimm` in, `r`: 5-bit immediate, zero-extended to 32 bits.
- `out` out, `word`: current value of the addressed register; 0 when `addr` matches none of the three.
- `irq` out, 1: `PEND & IE`.

## Operation
- CONFIG bit fields (all other bits read 0 and ignore writes):
  - bit0 EN
  - bit1 PERIODIC
  - bit2 IE
  - bits[4+PS_W-1:4] PS
  - bit8 PEND
- COMPARE and COUNTER are full 32-bit registers, both read/write.
- CSR write value, where operand is `rs1_data` or the zero-extended `rs1_zimm` for the I forms:
  - CSRRW/CSRRWI: new = operand.
  - CSRRS/CSRRSI: new = old | operand.
  - CSRRC/CSRRCI: new = old & ~operand.
- A write commits at the clock edge when `en=1` and `addr` hits. With `en=0` nothing changes.
- Prescaler:
  - Counts 0..2^PS-1 while EN=1.
  - A tick occurs in the cycle where the prescaler equals 2^PS-1, then the prescaler wraps to 0. PS=0 gives a tick every cycle.
  - The prescaler is held at 0 while EN=0, and is cleared on any CONFIG write.
- On a tick:
  - If COUNTER == COMPARE, a match occurs:
    - PEND <= 1.
    - PERIODIC=1: COUNTER <= 0.
    - PERIODIC=0: COUNTER holds and EN <= 0 (one-shot).
  - Otherwise COUNTER <= COUNTER+1, modulo 2^32 (0xFFFFFFFF wraps to 0).
- Period is (COMPARE+1)·2^PS cycles.
- PEND is cleared only by a software write, typically CSRRC with operand bit8 set.
- Simultaneous events:
  - A software write to COUNTER or CONFIG in the same cycle as a hardware update: the software value wins for every written field, except PEND.
  - Hardware set of PEND wins over a software clear in the same cycle.
  - A software write to COMPARE in a match cycle: the match uses the old COMPARE.
- Reset: CONFIG, COMPARE, COUNTER and the prescaler go to 0, so `irq`=0. `out` then reads 0 at every address. Reset mid-count discards all state.

## Timing
- `out` is combinational from `addr` and register state. Written data is visible on `out` the cycle after the write edge (read-before-write value in the write cycle).
- `irq` is combinational from registered PEND and IE, so it rises the cycle after the match edge.
- No stalls, no backpressure; one access per cycle.

## Structure
- Field bit positions for CONFIG (EN, PERIODIC, IE, PS, PEND) go in `decoder_pkg` as constants next to `csr_t`. `csr_t`, `csr_addr_t`, `word` and `r` are reused from `decoder_pkg`.
- One combinational sub-module, `csr_wdata`, computes the new value from (old, `op`, `rs1_data`, `rs1_zimm`). The plain `csr` register should share it.

## Test plan
- Reset, then read all three addresses and `BASE_ADDR+3` -> `out`=0 for each; `irq`=0.
- CSRRW COMPARE=3, then CSRRWI CONFIG=`'b00111` (EN, PERIODIC, IE, PS=0) -> COUNTER reads 0,1,2,3,0,… Match every 4 cycles; `irq`=1 one cycle after the first match.
- CONFIG=EN only, PS=2, COMPARE=1 -> COUNTER increments every 4 cycles. Match at cycle 8 sets PEND, clears EN, and COUNTER holds at 1.
- With PEND=1, CSRRC CONFIG operand `'h100` -> PEND=0 and `irq`=0 next cycle. Repeat the clear in exactly a match cycle -> PEND stays 1.
- CSRRW COUNTER=`'hFFFFFFFF`, COMPARE=5, EN, PS=0 -> COUNTER wraps to 0, then matches at 5.
- Assert `reset` mid-count -> all registers read 0 the next cycle and `irq`=0.
